// File: rtl/fixed_div.sv
// Signed fixed-point divider: pops a {num, den} pair, divides with a restoring radix-2
// loop over |num|<<Q_BITS and presents the saturated quotient on a FWFT output register.
module fixed_div #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_BITS     = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] num,
    input  logic [DATA_WIDTH-1:0] den,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_dz,
    output logic                  out_empty,
    input  logic                  out_rd_en
);

    localparam int DW = DATA_WIDTH;
    localparam int N  = DATA_WIDTH + Q_BITS;
    localparam int CW = $clog2(N);

    localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [N-1:0]  LIM_POS = {{(N-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [N-1:0]  LIM_NEG = {{(N-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LAST    = CW'(N-1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the magnitude of the most negative value is representable.
    function automatic logic [DW:0] mag(input logic [DW-1:0] v);
        logic [DW:0] ext;
        ext = {v[DW-1], v};
        if (v[DW-1]) begin
            mag = (~ext) + {{DW{1'b0}}, 1'b1};
        end else begin
            mag = ext;
        end
    endfunction

    function automatic logic [DW-1:0] saturate(input logic [N-1:0] q, input logic neg);
        if (!neg && (q > LIM_POS)) begin
            saturate = SAT_POS;
        end else if (neg && (q > LIM_NEG)) begin
            saturate = SAT_NEG;
        end else if (neg) begin
            saturate = (~q[DW-1:0]) + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            saturate = q[DW-1:0];
        end
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    div_q, div_d;
    logic [DW:0]     rem_q, rem_d;
    logic [DW:0]     den_q, den_d;
    logic            neg_q, neg_d;
    logic [DW-1:0]   out_q, out_d;
    logic            out_dz_q, out_dz_d;
    logic            out_empty_q, out_empty_d;

    logic [DW+1:0]   rem_shift_s;
    logic            ge_s;
    logic [DW:0]     rem_next_s;
    logic [N-1:0]    quo_next_s;
    logic [DW:0]     num_mag_s;
    logic            pop_s;

    assign out       = out_q;
    assign out_dz    = out_dz_q;
    assign out_empty = out_empty_q;

    // One restoring step: dividend bits shift out of div_q while quotient bits shift in.
    always_comb begin
        rem_shift_s = {rem_q, div_q[N-1]};
        ge_s        = (rem_shift_s >= {1'b0, den_q});
        rem_next_s  = ge_s ? (rem_shift_s[DW:0] - den_q) : rem_shift_s[DW:0];
        quo_next_s  = {div_q[N-2:0], ge_s};
        num_mag_s   = mag(num);
        pop_s       = (state_q == DONE) && !out_empty_q && out_rd_en;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        rem_d       = rem_q;
        den_d       = den_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_dz_d    = out_dz_q;
        out_empty_d = 1'b1;
        in_rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_rd_en = !in_empty;
                if (!in_empty) begin
                    den_d = mag(den);
                    neg_d = num[DW-1] ^ den[DW-1];
                    div_d = N'({num_mag_s, {Q_BITS{1'b0}}});
                    rem_d = {(DW+1){1'b0}};
                    cnt_d = {CW{1'b0}};
                    if (den == {DW{1'b0}}) begin
                        out_d    = num[DW-1] ? SAT_NEG : SAT_POS;
                        out_dz_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                div_d = quo_next_s;
                rem_d = rem_next_s;
                if (cnt_q == LAST) begin
                    out_d    = saturate(quo_next_s, neg_q);
                    out_dz_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                // out_empty drops one edge after entering DONE, so a pop is only seen after that.
                if (pop_s) begin
                    state_d = IDLE;
                end else begin
                    out_empty_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            div_q       <= {N{1'b0}};
            rem_q       <= {(DW+1){1'b0}};
            den_q       <= {(DW+1){1'b0}};
            neg_q       <= 1'b0;
            out_q       <= {DW{1'b0}};
            out_dz_q    <= 1'b0;
            out_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_dz_q    <= out_dz_d;
            out_empty_q <= out_empty_d;
        end
    end

endmodule

// File: tb/tb_fixed_div.sv
// Directed and random scoreboard bench for fixed_div (Q22.10, 32-bit).
module tb_fixed_div;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] num, den;
    logic        in_empty, in_rd_en;
    logic [31:0] out;
    logic        out_dz, out_empty, out_rd_en;

    fixed_div #(.DATA_WIDTH(32), .Q_BITS(10)) dut (
        .clock(clock), .reset(reset), .num(num), .den(den),
        .in_empty(in_empty), .in_rd_en(in_rd_en),
        .out(out), .out_dz(out_dz), .out_empty(out_empty), .out_rd_en(out_rd_en)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int acc_cycle = 0;
    int pop_cycle = 0;
    int n_acc = 0;
    logic [63:0] fifo_q[$];
    logic [32:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Golden reference: 64-bit integer arithmetic on magnitudes.
    function automatic logic [32:0] model(input logic [31:0] n, input logic [31:0] d);
        longint sn, sd, a, b, q, r;
        logic neg;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        a = (sn < 0) ? -sn : sn;
        b = (sd < 0) ? -sd : sd;
        if (b == 0) begin
            if (n[31]) return {1'b1, 32'h8000_0000};
            else return {1'b1, 32'h7FFF_FFFF};
        end
        q = (a * 64'sd1024) / b;
        neg = n[31] ^ d[31];
        if (!neg && q > 64'sd2147483647) return {1'b0, 32'h7FFF_FFFF};
        if (neg && q > 64'sd2147483648) return {1'b0, 32'h8000_0000};
        r = neg ? -q : q;
        return {1'b0, r[31:0]};
    endfunction

    task automatic drive_up();
        if (fifo_q.size() == 0) begin
            in_empty = 1'b1;
            num = 32'd0;
            den = 32'd0;
        end else begin
            in_empty = 1'b0;
            {num, den} = fifo_q[0];
        end
    endtask

    task automatic tick();
        logic acc;
        @(negedge clock);
        acc = in_rd_en && !reset;
        if (in_empty) check("rd_en_while_empty", 64'(in_rd_en), 64'd0);
        @(posedge clock);
        #1;
        cycle++;
        if (acc) begin
            void'(fifo_q.pop_front());
            n_acc++;
            acc_cycle = cycle;
            drive_up();
        end
    endtask

    task automatic push(input logic [31:0] n, input logic [31:0] d, input logic [32:0] e);
        fifo_q.push_back({n, d});
        sb_q.push_back(e);
        drive_up();
    endtask

    task automatic wait_accept();
        int start;
        start = n_acc;
        for (int i = 0; i < 8 && n_acc == start; i++) tick();
        check("accept", 64'(n_acc - start), 64'd1);
    endtask

    task automatic wait_result(input int budget, output int lat);
        for (int i = 0; i < budget && out_empty !== 1'b0; i++) tick();
        check("result_ready", 64'(out_empty), 64'd0);
        lat = cycle - acc_cycle;
    endtask

    task automatic pop_result(input string tag);
        logic [32:0] e;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 33'h1_DEAD_BEEF;
        check({tag, "_out"}, 64'(out), 64'(e[31:0]));
        check({tag, "_dz"}, 64'(out_dz), 64'(e[32]));
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        pop_cycle = cycle;
        check({tag, "_empty_after_pop"}, 64'(out_empty), 64'd1);
    endtask

    task automatic run_directed(input string tag, input logic [31:0] n, input logic [31:0] d,
                                input logic [32:0] e, input int exp_lat);
        int lat;
        push(n, d, e);
        wait_accept();
        wait_result(60, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        pop_result(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int start;
        logic [31:0] n, d;
        reset = 1'b1;
        out_rd_en = 1'b0;
        drive_up();
        repeat (3) tick();
        check("rst_out", 64'(out), 64'd0);
        check("rst_dz", 64'(out_dz), 64'd0);
        check("rst_empty", 64'(out_empty), 64'd1);
        check("rst_rd_en", 64'(in_rd_en), 64'd0);
        reset = 1'b0;
        tick();

        run_directed("div_3_1p5",  32'h0000_0C00, 32'h0000_0600, {1'b0, 32'h0000_0800}, 43);
        run_directed("neg1_4",     32'hFFFF_FC00, 32'h0000_1000, {1'b0, 32'hFFFF_FF00}, 43);
        run_directed("one_3",      32'h0000_0400, 32'h0000_0C00, {1'b0, 32'h0000_0155}, 43);
        run_directed("dz_pos",     32'h0000_0400, 32'h0000_0000, {1'b1, 32'h7FFF_FFFF}, 1);
        run_directed("dz_neg",     32'hFFFF_F800, 32'h0000_0000, {1'b1, 32'h8000_0000}, 1);
        run_directed("dz_zero",    32'h0000_0000, 32'h0000_0000, {1'b1, 32'h7FFF_FFFF}, 1);
        run_directed("sat_pos",    32'h7FFF_FFFF, 32'h0000_0001, {1'b0, 32'h7FFF_FFFF}, 43);
        run_directed("sat_neg",    32'h8000_0000, 32'h0000_0001, {1'b0, 32'h8000_0000}, 43);
        run_directed("min_by_m1",  32'h8000_0000, 32'hFFFF_FC00, {1'b0, 32'h7FFF_FFFF}, 43);
        run_directed("min_by_1",   32'h8000_0000, 32'h0000_0400, {1'b0, 32'h8000_0000}, 43);

        // Backpressure: two pairs queued, consumer stalls for 100 cycles.
        start = n_acc;
        push(32'h0000_1800, 32'h0000_0800, {1'b0, 32'h0000_0C00});
        push(32'h0000_0400, 32'hFFFF_F800, {1'b0, 32'hFFFF_FE00});
        wait_accept();
        wait_result(60, lat);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("bp_hold_out", 64'(out), 64'h0000_0C00);
        end
        check("bp_single_pop", 64'(n_acc - start), 64'd1);
        check("bp_hold_empty", 64'(out_empty), 64'd0);
        pop_result("bp_first");
        tick();
        check("bp_next_accept", 64'(acc_cycle), 64'(pop_cycle + 1));
        wait_result(60, lat);
        pop_result("bp_second");

        // Reset 20 cycles into a division; the partial result must vanish.
        push(32'h0000_1400, 32'h0000_0400, {1'b0, 32'h0000_1400});
        wait_accept();
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_empty", 64'(out_empty), 64'd1);
        void'(sb_q.pop_front());
        repeat (30) tick();
        check("midrst_discarded", 64'(out_empty), 64'd1);
        run_directed("after_rst", 32'hFFFF_F000, 32'h0000_0C00, {1'b0, 32'hFFFF_FAAB}, 43);

        // Random stream, order checked through the scoreboard queue.
        for (int k = 0; k < 1000; k++) begin
            n = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                d = 32'd0;
            end else begin
                d = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) d = ~d + 32'd1;
            end
            push(n, d, model(n, d));
        end
        for (int k = 0; k < 1000; k++) begin
            wait_result(100, lat);
            repeat ($urandom_range(0, 2)) tick();
            pop_result("stream");
        end
        check("stream_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
